matrix_stream_loader: RTL and testbench
=======================================

Name: matrix_stream_loader

Overview:
- Parses the host byte stream for the matrix multiplier: a size header N, then N×N elements of A, then N×N elements of B, all row-major.
- Writes each element into the A/B operand buffers.
- Generalises the fixed 2×2, 8-bit load sequence to run-time N ≤ MAX_N, multi-byte elements, inter-byte timeout and error reporting.
- Sits between the UART receiver (byte strobe) and the operand RAMs / multiply controller.

Parameters:
- DATA_W, 8, element width in bits; must be a multiple of 8. BPE = DATA_W/8 bytes per element, received little-endian.
- MAX_N, 8, largest accepted matrix dimension; must be at least 1.
- ADDR_W, $clog2(MAX_N*MAX_N), buffer address width.
- TIMEOUT_CYC, 2000000, idle cycles allowed between bytes while a load is in progress.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- next  in  1  pulse from the multiply controller: operands consumed, re-arm for the next load.
- clr_err  in  1  pulse: clears err_code.
- wr_en  out  1  buffer write strobe.
- wr_sel  out  1  0 = A buffer, 1 = B buffer.
- wr_addr  out  ADDR_W  row*MAX_N + col.
- wr_data  out  DATA_W  assembled element.
- mat_n  out  $clog2(MAX_N+1)  latched dimension.
- load_done  out  1  one-cycle pulse: both matrices fully written.
- busy  out  1  high in LOAD_A, LOAD_B and CSUM.
- err_code  out  2  sticky: 00 none, 01 bad size, 10 timeout, 11 checksum.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs are 0; row, col, byte index and timeout counter are 0.
- IDLE:
  - rx_valid with 1 ≤ rx_data ≤ MAX_N: latch mat_n, go to LOAD_A.
  - rx_valid with 0 or > MAX_N: err_code = 01, stay in IDLE.
- LOAD_A / LOAD_B:
  - Each rx_valid shifts the byte into an element shift register at byte position idx. idx counts 0..BPE-1 and wraps.
  - On the last byte of an element, the next cycle drives wr_en = 1 for exactly one cycle with wr_data, wr_addr and wr_sel. Write latency is 1 cycle after that rx_valid.
  - col increments and wraps at mat_n-1; row then increments.
  - After element (mat_n-1, mat_n-1):
    - LOAD_A goes to LOAD_B, with row and col reset to 0.
    - LOAD_B goes to DONE (or to CSUM when CHECKSUM_EN is defined).
  - Addresses always use stride MAX_N, not mat_n.
- DONE:
  - load_done pulses in the same cycle as the final wr_en.
  - The state holds until next, then returns to IDLE. mat_n is retained.
  - Bytes arriving in DONE are dropped, with no error.
- Timeout:
  - In LOAD_A, LOAD_B and CSUM, the counter resets on every rx_valid and increments otherwise.
  - Reaching TIMEOUT_CYC sets err_code = 10 and aborts to IDLE. No load_done is issued; partial writes stay in the buffer.
- Simultaneous events:
  - rx_valid in the same cycle the counter reaches TIMEOUT_CYC: the byte wins and no timeout occurs.
  - clr_err and a new error in the same cycle: the new error wins.
  - next outside DONE is ignored.
- err_code does not block operation. A new size header starts a load while err_code is non-zero.
- A later error overwrites an earlier one. Only clr_err or reset clears err_code.
- Reset mid-load discards all progress. Buffer contents are not cleared.

Optional Feature:
- Macro: MATRIX_LOADER_CHECKSUM_EN.
- Defined:
  - After the last B element the block enters CSUM and expects one trailer byte.
  - The trailer must equal the XOR of every byte received, from the size header through the last B byte.
  - Match: load_done pulses one cycle after the trailer byte.
  - Mismatch: err_code = 11, no load_done, return to IDLE.
- Undefined: no CSUM state and no trailer; load_done behaves as described above.

Test Plan:
- 2×2 load, DATA_W=8, MAX_N=4, bytes 02,01,02,03,04,05,06,07,08.
  - Expect A writes addr 0,1,4,5 with data 1,2,3,4, then B writes addr 0,1,4,5 with data 5,6,7,8.
  - mat_n = 2; load_done coincident with the B[5]=8 write; busy falls.
- Size header 00, then 09 with MAX_N=8.
  - Expect err_code = 01 each time, no wr_en, state stays IDLE.
  - A following 01,AA,BB loads A[0]=AA and B[0]=BB.
- DATA_W=16, size 01, bytes 34,12,78,56.
  - Expect A[0] = 0x1234 and B[0] = 0x5678.
  - wr_en fires only after the second byte of each element.
- Size 02, three A bytes, then silence for TIMEOUT_CYC (set to 100).
  - Expect err_code = 10 at cycle 100, busy = 0, no load_done.
  - clr_err returns err_code to 00.
- rst pulled low after size 02 and two A bytes, then released.
  - Expect all outputs 0 immediately.
  - A full 2×2 sequence then loads correctly from addr 0.
- MATRIX_LOADER_CHECKSUM_EN defined, the 2×2 stream plus trailer 0A.
  - Expect load_done one cycle after the trailer.
  - Trailer 0B instead: expect err_code = 11 and no load_done.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//
// Parses the host byte stream feeding the matrix multiplier. The stream is a
// size header N (1..MAX_N), then N*N elements of A, then N*N elements of B,
// both row-major. Elements are DATA_W bits wide and arrive little-endian,
// DATA_W/8 bytes each. Every completed element is written to the A or B
// operand buffer at address row*MAX_N + col.
//
// Optional build macro: MATRIX_LOADER_CHECKSUM_EN
//   When defined, one trailer byte follows the last B byte. It must equal the
//   XOR of every byte from the size header through the last B byte. load_done
//   is issued only when the trailer matches.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   next       multiply controller consumed the operands; re-arm
//   clr_err    clears err_code
//   wr_en      buffer write strobe (one cycle per element)
//   wr_sel     0 = A buffer, 1 = B buffer
//   wr_addr    row*MAX_N + col
//   wr_data    assembled element
//   mat_n      latched matrix dimension
//   load_done  one-cycle pulse when the load has completed
//   busy       high while a load (or trailer wait) is in progress
//   err_code   sticky: 00 none, 01 bad size, 10 timeout, 11 checksum
// -----------------------------------------------------------------------------
module matrix_stream_loader #(
  parameter int DATA_W      = 8,
  parameter int MAX_N       = 8,
  parameter int ADDR_W      = $clog2(MAX_N * MAX_N),
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       next,
  input  logic                       clr_err,
  output logic                       wr_en,
  output logic                       wr_sel,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(MAX_N+1)-1:0] mat_n,
  output logic                       load_done,
  output logic                       busy,
  output logic [1:0]                 err_code
);

  localparam int BPE   = DATA_W / 8;
  localparam int NW    = $clog2(MAX_N + 1);
  localparam int IDX_W = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       ERR_SIZE = 2'b01;
  localparam logic [1:0]       ERR_TIME = 2'b10;

`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    DONE   = 3'd3,
    CSUM   = 3'd4
  } state_t;

  // Running stream checksum: plain XOR fold of every byte.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    DONE   = 3'd3
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [NW-1:0]     mat_n_r, mat_n_s;
  logic [NW-1:0]     row_r, row_s;
  logic [NW-1:0]     col_r, col_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0] elem_r, elem_s;
  logic [DATA_W-1:0] asm_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [1:0]        err_r, err_s;
  logic              wr_en_r, wr_en_s;
  logic              wr_sel_r, wr_sel_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_s;
  logic              load_done_r, load_done_s;
  logic              busy_r, busy_s;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [7:0]        csum_r, csum_s;
`endif

  // Element assembly: the current byte replaces the slot selected by idx_r.
  always_comb begin
    asm_s = elem_r;
    for (int i = 0; i < BPE; i++) begin
      if (idx_r == IDX_W'(i)) begin
        asm_s[i*8 +: 8] = rx_data;
      end else begin
        asm_s[i*8 +: 8] = elem_r[i*8 +: 8];
      end
    end
  end

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_s     = state_r;
    mat_n_s     = mat_n_r;
    row_s       = row_r;
    col_s       = col_r;
    idx_s       = idx_r;
    elem_s      = elem_r;
    cnt_s       = cnt_r;
    wr_en_s     = 1'b0;
    wr_sel_s    = wr_sel_r;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
    load_done_s = 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    csum_s      = csum_r;
`endif
    // A new error raised below overrides a simultaneous clear.
    if (clr_err) begin
      err_s = 2'b00;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data != 8'd0) && (int'(rx_data) <= MAX_N)) begin
            mat_n_s = NW'(rx_data);
            row_s   = '0;
            col_s   = '0;
            idx_s   = '0;
            cnt_s   = '0;
            state_s = LOAD_A;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            csum_s  = rx_data;
`endif
          end else begin
            err_s = ERR_SIZE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      LOAD_A, LOAD_B: begin
        if (rx_valid) begin
          cnt_s  = '0;
          elem_s = asm_s;
`ifdef MATRIX_LOADER_CHECKSUM_EN
          csum_s = csum_fold(csum_r, rx_data);
`endif
          if (idx_r == IDX_LAST) begin
            idx_s     = '0;
            wr_en_s   = 1'b1;
            wr_sel_s  = (state_r == LOAD_B);
            // Buffer stride is always MAX_N so the multiplier can index
            // without knowing the run-time dimension.
            wr_addr_s = ADDR_W'(int'(row_r) * MAX_N + int'(col_r));
            wr_data_s = asm_s;
            if (col_r == mat_n_r - NW'(1)) begin
              col_s = '0;
              if (row_r == mat_n_r - NW'(1)) begin
                row_s = '0;
                if (state_r == LOAD_A) begin
                  state_s = LOAD_B;
                end else begin
`ifdef MATRIX_LOADER_CHECKSUM_EN
                  state_s = CSUM;
`else
                  state_s     = DONE;
                  load_done_s = 1'b1;
`endif
                end
              end else begin
                row_s = row_r + NW'(1);
              end
            end else begin
              col_s = col_r + NW'(1);
            end
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else if (cnt_r == CNT_LAST) begin
          // Byte-less cycle that would bring the counter to TIMEOUT_CYC.
          err_s   = ERR_TIME;
          state_s = IDLE;
          cnt_s   = '0;
          row_s   = '0;
          col_s   = '0;
          idx_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

`ifdef MATRIX_LOADER_CHECKSUM_EN
      CSUM: begin
        if (rx_valid) begin
          cnt_s = '0;
          if (rx_data == csum_r) begin
            state_s     = DONE;
            load_done_s = 1'b1;
          end else begin
            err_s   = ERR_CSUM;
            state_s = IDLE;
          end
        end else if (cnt_r == CNT_LAST) begin
          err_s   = ERR_TIME;
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`endif

      DONE: begin
        // Bytes arriving here are dropped silently.
        if (next) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == LOAD_A) || (state_s == LOAD_B);
`ifdef MATRIX_LOADER_CHECKSUM_EN
    busy_s = busy_s || (state_s == CSUM);
`endif
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      mat_n_r     <= '0;
      row_r       <= '0;
      col_r       <= '0;
      idx_r       <= '0;
      elem_r      <= '0;
      cnt_r       <= '0;
      err_r       <= 2'b00;
      wr_en_r     <= 1'b0;
      wr_sel_r    <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      load_done_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      state_r     <= state_s;
      mat_n_r     <= mat_n_s;
      row_r       <= row_s;
      col_r       <= col_s;
      idx_r       <= idx_s;
      elem_r      <= elem_s;
      cnt_r       <= cnt_s;
      err_r       <= err_s;
      wr_en_r     <= wr_en_s;
      wr_sel_r    <= wr_sel_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      load_done_r <= load_done_s;
      busy_r      <= busy_s;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      csum_r      <= csum_s;
`endif
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_sel    = wr_sel_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign mat_n     = mat_n_r;
  assign load_done = load_done_r;
  assign busy      = busy_r;
  assign err_code  = err_r;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_loader
//
// Two loader instances share clock and reset:
//   u0: DATA_W=8,  MAX_N=4, TIMEOUT_CYC=100
//   u1: DATA_W=16, MAX_N=8, TIMEOUT_CYC=100
// Expected buffer writes are derived from the byte stream by a reference
// model that walks element indices arithmetically. Follows the
// MATRIX_LOADER_CHECKSUM_EN build macro.
// -----------------------------------------------------------------------------
module tb_matrix_stream_loader;

  typedef logic [7:0] byte_q[$];
  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] data;
    int          stamp;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        rxv0 = 1'b0, nxt0 = 1'b0, clr0 = 1'b0;
  logic [7:0]  rxd0 = 8'h00;
  logic        wr_en0, wr_sel0, load_done0, busy0;
  logic [3:0]  wr_addr0;
  logic [7:0]  wr_data0;
  logic [2:0]  mat_n0;
  logic [1:0]  err0;

  logic        rxv1 = 1'b0, nxt1 = 1'b0, clr1 = 1'b0;
  logic [7:0]  rxd1 = 8'h00;
  logic        wr_en1, wr_sel1, load_done1, busy1;
  logic [5:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic [3:0]  mat_n1;
  logic [1:0]  err1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stamp = 0;

  wr_t wq0[$], wq1[$], exp_q[$];
  int  done0[$], done1[$];

  matrix_stream_loader #(.DATA_W(8), .MAX_N(4), .ADDR_W(4), .TIMEOUT_CYC(100)) u0 (
    .clk(clk), .rst(rst), .rx_valid(rxv0), .rx_data(rxd0), .next(nxt0), .clr_err(clr0),
    .wr_en(wr_en0), .wr_sel(wr_sel0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .mat_n(mat_n0), .load_done(load_done0), .busy(busy0), .err_code(err0));

  matrix_stream_loader #(.DATA_W(16), .MAX_N(8), .ADDR_W(6), .TIMEOUT_CYC(100)) u1 (
    .clk(clk), .rst(rst), .rx_valid(rxv1), .rx_data(rxd1), .next(nxt1), .clr_err(clr1),
    .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .mat_n(mat_n1), .load_done(load_done1), .busy(busy1), .err_code(err1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record buffer writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (wr_en0 === 1'b1) wq0.push_back({wr_sel0, 8'(wr_addr0), 16'(wr_data0), cyc});
    if (wr_en1 === 1'b1) wq1.push_back({wr_sel1, 8'(wr_addr1), wr_data1, cyc});
    if (load_done0 === 1'b1) done0.push_back(cyc);
    if (load_done1 === 1'b1) done1.push_back(cyc);
  end

  // Reference model: element e of matrix m comes from bytes starting at
  // 1 + (m*N*N + e)*bpe, little-endian, stored at (e/N)*maxn + e%N.
  function automatic void model_load(input int bpe, input int maxn, input byte_q s);
    int n;
    int v;
    wr_t w;
    n = int'(s[0]);
    exp_q.delete();
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < n * n; e++) begin
        v = 0;
        for (int j = 0; j < bpe; j++) v = v | (int'(s[1 + (m*n*n + e)*bpe + j]) << (8*j));
        w.sel   = (m == 1);
        w.addr  = 8'((e / n) * maxn + (e % n));
        w.data  = 16'(v);
        w.stamp = 0;
        exp_q.push_back(w);
      end
    end
  endfunction

`ifdef MATRIX_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_all(input byte_q s);
    logic [7:0] x;
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    return x;
  endfunction
`endif

  task automatic set_in(input int inst, input logic v, input logic [7:0] d, input logic nx, input logic ce);
    if (inst == 0) begin
      rxv0 = v; rxd0 = d; nxt0 = nx; clr0 = ce;
    end else begin
      rxv1 = v; rxd1 = d; nxt1 = nx; clr1 = ce;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send_byte(input int inst, input logic [7:0] b);
    set_in(inst, 1'b1, b, 1'b0, 1'b0);
    last_stamp = cyc;
    @(posedge clk); #1;
    set_in(inst, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse(input int inst, input logic nx, input logic ce);
    set_in(inst, 1'b0, 8'h00, nx, ce);
    @(posedge clk); #1;
    set_in(inst, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_en0, wr_sel0, wr_addr0, wr_data0, mat_n0, load_done0, busy0, err0} !== '0) begin
      errors++; $display("FAIL reset_u0: outputs=%h required 0", {wr_en0, wr_sel0, wr_addr0, wr_data0, mat_n0, load_done0, busy0, err0});
    end
    checks++;
    if ({wr_en1, wr_sel1, wr_addr1, wr_data1, mat_n1, load_done1, busy1, err1} !== '0) begin
      errors++; $display("FAIL reset_u1: outputs=%h required 0", {wr_en1, wr_sel1, wr_addr1, wr_data1, mat_n1, load_done1, busy1, err1});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_2x2();
    byte_q s;
    int data_stamp, exp_done;
    s = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    wq0.delete(); done0.delete();
    model_load(1, 4, s);
    foreach (s[i]) begin
      send_byte(0, s[i]);
      if (i == 0) begin
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL 2x2_busy: got %b required 1", busy0); end
      end
    end
    data_stamp = last_stamp;
    exp_done = data_stamp + 1;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(0, xor_all(s));
    exp_done = last_stamp + 1;
`endif
    idle(3);
    checks++;
    if (wq0.size() != exp_q.size()) begin errors++; $display("FAIL 2x2_count: got %0d writes required %0d", wq0.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq0.size() || wq0[i].sel !== exp_q[i].sel || wq0[i].addr !== exp_q[i].addr || wq0[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL 2x2_write[%0d]: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                           i, wq0[i].sel, wq0[i].addr, wq0[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (wq0.size() == 8 && wq0[7].stamp != data_stamp + 1) begin errors++; $display("FAIL 2x2_latency: got cycle %0d required %0d", wq0[7].stamp, data_stamp + 1); end
    checks++;
    if (done0.size() != 1 || done0[0] != exp_done) begin errors++; $display("FAIL 2x2_done: got %0d pulses first at %0d required 1 at %0d", done0.size(), (done0.size() > 0) ? done0[0] : -1, exp_done); end
    checks++;
    if (mat_n0 !== 3'd2) begin errors++; $display("FAIL 2x2_mat_n: got %0d required 2", mat_n0); end
    checks++;
    if (busy0 !== 1'b0 || err0 !== 2'b00) begin errors++; $display("FAIL 2x2_end: got busy=%b err=%b required busy=0 err=00", busy0, err0); end
    // A byte in DONE must be dropped without starting a load or flagging.
    send_byte(0, 8'h02);
    idle(2);
    checks++;
    if (wq0.size() != 8 || busy0 !== 1'b0 || err0 !== 2'b00) begin
      errors++; $display("FAIL done_drop: got writes=%0d busy=%b err=%b required 8 0 00", wq0.size(), busy0, err0);
    end
    pulse(0, 1'b1, 1'b0);
  endtask

  task automatic test_bad_size();
    byte_q s;
    wq0.delete(); done0.delete();
    send_byte(0, 8'h00);
    checks++;
    if (err0 !== 2'b01 || busy0 !== 1'b0) begin errors++; $display("FAIL size_zero: got err=%b busy=%b required 01 0", err0, busy0); end
    pulse(0, 1'b0, 1'b1);
    checks++;
    if (err0 !== 2'b00) begin errors++; $display("FAIL clr_err: got %b required 00", err0); end
    send_byte(0, 8'h05);
    checks++;
    if (err0 !== 2'b01 || busy0 !== 1'b0) begin errors++; $display("FAIL size_big: got err=%b busy=%b required 01 0", err0, busy0); end
    checks++;
    if (wq0.size() != 0 || mat_n0 !== 3'd2) begin errors++; $display("FAIL size_nowrite: got writes=%0d mat_n=%0d required 0 2", wq0.size(), mat_n0); end
    s = '{8'h01, 8'hAA, 8'hBB};
    model_load(1, 4, s);
    foreach (s[i]) send_byte(0, s[i]);
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(0, xor_all(s));
`endif
    idle(3);
    checks++;
    if (wq0.size() != exp_q.size()) begin errors++; $display("FAIL after_err_count: got %0d required %0d", wq0.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq0.size() || wq0[i].sel !== exp_q[i].sel || wq0[i].addr !== exp_q[i].addr || wq0[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL after_err_write[%0d]: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                           i, wq0[i].sel, wq0[i].addr, wq0[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (done0.size() != 1 || err0 !== 2'b01) begin errors++; $display("FAIL after_err_done: got done=%0d err=%b required 1 01", done0.size(), err0); end
    pulse(0, 1'b1, 1'b1);
    wq1.delete();
    send_byte(1, 8'h09);
    checks++;
    if (err1 !== 2'b01 || busy1 !== 1'b0 || wq1.size() != 0) begin
      errors++; $display("FAIL size_nine: got err=%b busy=%b writes=%0d required 01 0 0", err1, busy1, wq1.size());
    end
    pulse(1, 1'b0, 1'b1);
  endtask

  task automatic test_wide();
    byte_q s;
    int st[5];
    s = '{8'h01, 8'h34, 8'h12, 8'h78, 8'h56};
    wq1.delete(); done1.delete();
    model_load(2, 8, s);
    foreach (s[i]) begin send_byte(1, s[i]); st[i] = last_stamp; end
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(1, xor_all(s));
`endif
    idle(3);
    checks++;
    if (wq1.size() != 2) begin errors++; $display("FAIL wide_count: got %0d required 2", wq1.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq1.size() || wq1[i].sel !== exp_q[i].sel || wq1[i].addr !== exp_q[i].addr || wq1[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL wide_write[%0d]: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                           i, wq1[i].sel, wq1[i].addr, wq1[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (wq1.size() == 2 && (wq1[0].stamp != st[2] + 1 || wq1[1].stamp != st[4] + 1)) begin
      errors++; $display("FAIL wide_timing: got cycles %0d %0d required %0d %0d", wq1[0].stamp, wq1[1].stamp, st[2] + 1, st[4] + 1);
    end
    checks++;
    if (done1.size() != 1) begin errors++; $display("FAIL wide_done: got %0d required 1", done1.size()); end
    pulse(1, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    wq0.delete(); done0.delete();
    send_byte(0, 8'h02);
    for (int i = 0; i < 3; i++) send_byte(0, 8'($urandom_range(0, 255)));
    repeat (99) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err0 !== 2'b00 || busy0 !== 1'b1) begin errors++; $display("FAIL timeout_early: got err=%b busy=%b required 00 1", err0, busy0); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (err0 !== 2'b10 || busy0 !== 1'b0) begin errors++; $display("FAIL timeout_hit: got err=%b busy=%b required 10 0", err0, busy0); end
    checks++;
    if (done0.size() != 0 || wq0.size() != 3) begin errors++; $display("FAIL timeout_partial: got done=%0d writes=%0d required 0 3", done0.size(), wq0.size()); end
    @(posedge clk); #1;
    // Clear and a new bad-size error in the same cycle: the error wins.
    set_in(0, 1'b1, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (err0 !== 2'b01) begin errors++; $display("FAIL clr_vs_err: got %b required 01", err0); end
    pulse(0, 1'b0, 1'b1);
    checks++;
    if (err0 !== 2'b00) begin errors++; $display("FAIL timeout_clr: got %b required 00", err0); end
  endtask

  task automatic test_reset_midload();
    byte_q s;
    send_byte(0, 8'h02);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wr_en0, wr_sel0, wr_addr0, wr_data0, mat_n0, load_done0, busy0, err0} !== '0) begin
      errors++; $display("FAIL midload_reset: outputs=%h required 0", {wr_en0, wr_sel0, wr_addr0, wr_data0, mat_n0, load_done0, busy0, err0});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    s = '{8'h02};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom_range(0, 255)));
    wq0.delete(); done0.delete();
    model_load(1, 4, s);
    foreach (s[i]) send_byte(0, s[i]);
`ifdef MATRIX_LOADER_CHECKSUM_EN
    send_byte(0, xor_all(s));
`endif
    idle(3);
    checks++;
    if (wq0.size() != exp_q.size() || done0.size() != 1) begin
      errors++; $display("FAIL reload_count: got writes=%0d done=%0d required %0d 1", wq0.size(), done0.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wq0.size() || wq0[i].sel !== exp_q[i].sel || wq0[i].addr !== exp_q[i].addr || wq0[i].data !== exp_q[i].data) begin
        errors++; $display("FAIL reload_write[%0d]: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                           i, wq0[i].sel, wq0[i].addr, wq0[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
      end
    end
    pulse(0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    byte_q s;
    wr_t got[$];
    int inst, maxn, bpe, n, ndone, mn;
    for (int it = 0; it < 6; it++) begin
      inst = it % 2;
      maxn = (inst == 0) ? 4 : 8;
      bpe  = (inst == 0) ? 1 : 2;
      n    = $urandom_range(1, maxn);
      s = '{8'(n)};
      for (int k = 0; k < 2 * n * n * bpe; k++) s.push_back(8'($urandom_range(0, 255)));
      wq0.delete(); wq1.delete(); done0.delete(); done1.delete();
      model_load(bpe, maxn, s);
      foreach (s[i]) begin
        idle($urandom_range(0, 3));
        send_byte(inst, s[i]);
      end
`ifdef MATRIX_LOADER_CHECKSUM_EN
      idle($urandom_range(0, 3));
      send_byte(inst, xor_all(s));
`endif
      idle(3);
      if (inst == 0) begin
        got = wq0; ndone = done0.size(); mn = int'(mat_n0);
      end else begin
        got = wq1; ndone = done1.size(); mn = int'(mat_n1);
      end
      checks++;
      if (got.size() != exp_q.size() || ndone != 1 || mn != n) begin
        errors++; $display("FAIL rand%0d_summary: got writes=%0d done=%0d mat_n=%0d required %0d 1 %0d", it, got.size(), ndone, mn, exp_q.size(), n);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got.size() || got[i].sel !== exp_q[i].sel || got[i].addr !== exp_q[i].addr || got[i].data !== exp_q[i].data) begin
          errors++; $display("FAIL rand%0d_write[%0d]: got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                             it, i, got[i].sel, got[i].addr, got[i].data, exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
        end
      end
      pulse(inst, 1'b1, 1'b0);
    end
  endtask

`ifdef MATRIX_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    byte_q s;
    s = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    wq0.delete(); done0.delete();
    foreach (s[i]) send_byte(0, s[i]);
    send_byte(0, 8'h0B);
    idle(3);
    checks++;
    if (err0 !== 2'b11 || done0.size() != 0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL csum_bad: got err=%b done=%0d busy=%b required 11 0 0", err0, done0.size(), busy0);
    end
    pulse(0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_load_2x2();
    test_bad_size();
    test_wide();
    test_timeout();
    test_reset_midload();
`ifdef MATRIX_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
